// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: execute-stage controls, instruction-memory port and the
// decode-facing outputs of the instruction fetch unit.
interface inst_fetch_unit_if;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] inst_in;
  logic [31:0] pc_addr;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        fetch_err;

  modport master (
    input  stall, halt, branch_taken, branch_imm, jump, jump_index, inst_in,
    output pc_addr, inst_out, pc_plus4, inst_valid, fetch_err
  );

  modport slave (
    output stall, halt, branch_taken, branch_imm, jump, jump_index, inst_in,
    input  pc_addr, inst_out, pc_plus4, inst_valid, fetch_err
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, presents it to instruction memory and
// forwards the fetched word to decode; next PC is +4, beq target or j target.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input logic                      clk,
  input logic                      rst,
  inst_fetch_unit_if.master        fetch_io
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt, StErr} state_e;

  localparam logic [32:0] PcLimit = 33'(MEM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        next_pc_bad;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{fetch_io.branch_imm[15]}}, fetch_io.branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (fetch_io.jump) begin
      next_pc = {pc_plus4[31:28], fetch_io.jump_index, 2'b00};
    end else if (fetch_io.branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // Wrapped adds land at high addresses, so the range check also catches them.
  assign next_pc_bad = ({1'b0, next_pc} >= PcLimit) || (next_pc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StBoot: state_d = (RESET_PC[1:0] != 2'b00) ? StErr : StRun;
      StRun: begin
        if (fetch_io.halt) begin
          state_d = StHalt;
        end else if (!fetch_io.stall) begin
          if (next_pc_bad) begin
            state_d = StErr;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    fetch_io.pc_addr    = pc_q;
    fetch_io.pc_plus4   = pc_plus4;
    fetch_io.inst_valid = (state_q == StRun);
    fetch_io.inst_out   = (state_q == StRun) ? fetch_io.inst_in : 32'd0;
    fetch_io.fetch_err  = (state_q == StErr);
  end

endmodule
